// File: rtl/axil_cmd_master.sv
// Single-outstanding command interface to AXI-lite master bridge (no strobes, no resp codes).
// Define AXIL_MST_TIMEOUT_EN to enable the watchdog abort after TIMEOUT_CYCLES.
module axil_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              rready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                b_seen_q, b_seen_d;
  logic                ar_done_q, ar_done_d;
  logic                r_seen_q, r_seen_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_complete, rd_complete, complete, accept, expire;

  assign aw_hs  = awvalid_q & awready;
  assign w_hs   = wvalid_q & wready;
  assign b_hs   = bvalid & bready_q;
  assign ar_hs  = arvalid_q & arready;
  assign r_hs   = rvalid & rready_q;
  assign accept = (state_q == IDLE) & cmd_valid;

  // Completion includes handshakes landing in the current cycle.
  assign wr_complete = (state_q == WRITE) & (aw_done_q | aw_hs) & (w_done_q | w_hs) & (b_seen_q | b_hs);
  assign rd_complete = (state_q == READ) & (ar_done_q | ar_hs) & (r_seen_q | r_hs);
  assign complete    = wr_complete | rd_complete;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;

  assign expire  = ((state_q == WRITE) | (state_q == READ)) & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else if ((state_q == WRITE) | (state_q == READ)) begin
      cnt_q <= cnt_q + 1'b1;
      if (expire & ~complete) rsp_err_q <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_seen_d    = b_seen_q;
    ar_done_d   = ar_done_q;
    r_seen_d    = r_seen_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            state_d   = WRITE;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            b_seen_d  = 1'b0;
          end else begin
            state_d   = READ;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            ar_done_d = 1'b0;
            r_seen_d  = 1'b0;
          end
        end
      end

      WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (b_hs) b_seen_d = 1'b1;
        if (wr_complete) begin
          state_d     = RESP;
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
        end else if (expire) begin
          state_d     = RESP;
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      READ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          ar_done_d = 1'b1;
        end
        // Only the first beat is kept; rready stays high but a stray beat must not overwrite it.
        if (r_hs & ~r_seen_q) begin
          r_seen_d    = 1'b1;
          rsp_rdata_d = rdata;
        end
        if (rd_complete) begin
          state_d  = RESP;
          rready_d = 1'b0;
        end else if (expire) begin
          state_d     = RESP;
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_seen_q    <= 1'b0;
      ar_done_q   <= 1'b0;
      r_seen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      b_seen_q    <= b_seen_d;
      ar_done_q   <= ar_done_d;
      r_seen_q    <= r_seen_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;

endmodule
